// File: rtl/kf_gain_update.sv
// -----------------------------------------------------------------------------
// kf_gain_update
//
// Scalar Kalman-filter measurement update in signed fixed point (N bits total,
// FRAC fractional bits). One operand set is processed at a time:
//
//   S  = sat(p + r)            -> presented on s_den to an external reciprocal
//   e  = sat(z - x)               unit that returns s_recip combinationally
//   K  = mul(p, 1/S)
//   x' = sat(x + mul(K, e))
//   p' = sat(p - mul(K, p))
//
// A single shared multiplier produces one product per cycle (GAIN, XUPD, PUPD).
// A non-positive S flags err and forces the reciprocal to zero, which makes
// K = 0, x' = x and p' = p fall out of the normal datapath.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready high only in IDLE)
//   x_pred, p_pred,       predicted state / covariance,
//   r_meas, z_meas        measurement noise / measurement
//   s_den / s_recip       innovation covariance out, its reciprocal back
//   out_valid / out_ready result handshake (out_valid high only in DONE)
//   x_upd, p_upd, k_gain  updated state, updated covariance, Kalman gain
//   err                   S was non-positive for this update
//
// Timing: accept edge -> RECIP -> GAIN -> XUPD -> PUPD -> DONE, so out_valid
// rises four edges after the accept edge; with out_ready already high the next
// accept can happen six cycles after the previous one.
// -----------------------------------------------------------------------------
module kf_gain_update #(
  parameter int N    = 20,
  parameter int FRAC = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [N-1:0] x_pred,
  input  logic signed [N-1:0] p_pred,
  input  logic signed [N-1:0] r_meas,
  input  logic signed [N-1:0] z_meas,
  output logic signed [N-1:0] s_den,
  input  logic signed [N-1:0] s_recip,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [N-1:0] x_upd,
  output logic signed [N-1:0] p_upd,
  output logic signed [N-1:0] k_gain,
  output logic                err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECIP = 3'd1,
    GAIN  = 3'd2,
    XUPD  = 3'd3,
    PUPD  = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Saturation limits at N bits and sign-extended to the 2N-bit product width.
  localparam logic signed [N-1:0]   MAX_V = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0]   MIN_V = {1'b1, {(N-1){1'b0}}};
  localparam logic signed [2*N-1:0] MAX_W = {{(N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [2*N-1:0] MIN_W = {{(N+1){1'b1}}, {(N-1){1'b0}}};

  // Clamp an (N+1)-bit sum/difference to N bits: overflow is visible as the
  // two top bits disagreeing, and the top bit then gives the true sign.
  function automatic logic signed [N-1:0] sat_n1(input logic signed [N:0] v);
    if (v[N] != v[N-1]) begin
      return v[N] ? MIN_V : MAX_V;
    end
    return $signed(v[N-1:0]);
  endfunction

  // Clamp a 2N-bit value to N bits.
  function automatic logic signed [N-1:0] sat_wide(input logic signed [2*N-1:0] v);
    if (v > MAX_W) begin
      return MAX_V;
    end
    if (v < MIN_W) begin
      return MIN_V;
    end
    return $signed(v[N-1:0]);
  endfunction

  // Saturating add or subtract of two N-bit operands, done one bit wider.
  function automatic logic signed [N-1:0] add_sat(input logic signed [N-1:0] a,
                                                  input logic signed [N-1:0] b,
                                                  input logic            sub);
    logic signed [N:0] a_x;
    logic signed [N:0] b_x;
    a_x = $signed({a[N-1], a});
    b_x = $signed({b[N-1], b});
    return sat_n1(sub ? (a_x - b_x) : (a_x + b_x));
  endfunction

  state_t state;
  state_t state_nxt;

  // Operands captured at accept; the inputs may change right after that edge.
  logic signed [N-1:0] x_r;
  logic signed [N-1:0] p_r;
  logic signed [N-1:0] e_r;
  logic signed [N-1:0] inv_r;

  // Shared multiplier.
  logic signed [N-1:0]   mul_a;
  logic signed [N-1:0]   mul_b;
  logic signed [2*N-1:0] prod;
  logic signed [2*N-1:0] prod_shr;
  logic signed [N-1:0]   mul_res;
  logic                  s_nonpos;

  // NOTE: every signal assigned in an always_comb gets a default on entry so
  // no path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    unique case (state)
      GAIN: begin
        mul_a = p_r;
        mul_b = inv_r;
      end
      XUPD: begin
        mul_a = k_gain;
        mul_b = e_r;
      end
      PUPD: begin
        mul_a = k_gain;
        mul_b = p_r;
      end
      default: ;
    endcase
  end

  // Full-width signed product; >>> on a signed value floors toward -inf.
  assign prod     = $signed({{N{mul_a[N-1]}}, mul_a}) * $signed({{N{mul_b[N-1]}}, mul_b});
  assign prod_shr = prod >>> FRAC;
  assign mul_res  = sat_wide(prod_shr);

  assign s_nonpos = s_den[N-1] || (s_den == '0);

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid) state_nxt = RECIP;
      RECIP:   state_nxt = GAIN;
      GAIN:    state_nxt = XUPD;
      XUPD:    state_nxt = PUPD;
      PUPD:    state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      x_r    <= '0;
      p_r    <= '0;
      e_r    <= '0;
      inv_r  <= '0;
      s_den  <= '0;
      x_upd  <= '0;
      p_upd  <= '0;
      k_gain <= '0;
      err    <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            x_r   <= x_pred;
            p_r   <= p_pred;
            e_r   <= add_sat(z_meas, x_pred, 1'b1);
            s_den <= add_sat(p_pred, r_meas, 1'b0);
            err   <= 1'b0;
          end
        end
        RECIP: begin
          // s_den has been stable for this whole cycle, so s_recip is settled.
          if (s_nonpos) begin
            inv_r <= '0;
            err   <= 1'b1;
          end else begin
            inv_r <= s_recip;
          end
        end
        GAIN:    k_gain <= mul_res;
        XUPD:    x_upd  <= add_sat(x_r, mul_res, 1'b0);
        PUPD:    p_upd  <= add_sat(p_r, mul_res, 1'b1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_kf_gain_update.sv
// -----------------------------------------------------------------------------
// tb_kf_gain_update
//
// Self-checking bench for kf_gain_update (N=20, FRAC=10). The external
// reciprocal unit is modelled as floor(2^20 / s_den), clamped to the positive
// maximum, and 0x7FFFF for a non-positive denominator. Expected results come
// from the worked examples (directed cases) or from an arithmetic model of
// the update equations (random cases).
// -----------------------------------------------------------------------------
module tb_kf_gain_update;

  localparam int     N    = 20;
  localparam int     FRAC = 10;
  localparam longint MAXV = (longint'(1) << (N - 1)) - 1;
  localparam longint MINV = -(longint'(1) << (N - 1));

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic                err;
  logic signed [N-1:0] x_pred = '0;
  logic signed [N-1:0] p_pred = '0;
  logic signed [N-1:0] r_meas = '0;
  logic signed [N-1:0] z_meas = '0;
  logic signed [N-1:0] s_den;
  logic signed [N-1:0] s_recip;
  logic signed [N-1:0] x_upd;
  logic signed [N-1:0] p_upd;
  logic signed [N-1:0] k_gain;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    longint s;
    longint k;
    longint x;
    longint p;
    bit     e;
  } res_t;

  typedef struct {
    longint x;
    longint p;
    longint r;
    longint z;
    res_t   exp;
  } vec_t;

  kf_gain_update #(.N(N), .FRAC(FRAC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_pred    (x_pred),
    .p_pred    (p_pred),
    .r_meas    (r_meas),
    .z_meas    (z_meas),
    .s_den     (s_den),
    .s_recip   (s_recip),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_upd     (x_upd),
    .p_upd     (p_upd),
    .k_gain    (k_gain),
    .err       (err)
  );

  always #5 clk = ~clk;

  // ---------------- reference arithmetic ----------------
  function automatic longint sat(input longint v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  // Product scaled by 2^-FRAC, rounded toward minus infinity, then clamped.
  function automatic longint mulq(input longint a, input longint b);
    longint pr;
    longint one;
    longint q;
    one = longint'(1) << FRAC;
    pr  = a * b;
    q   = pr / one;
    if (pr < 0 && q * one != pr) q = q - 1;
    return sat(q);
  endfunction

  function automatic longint recip_val(input longint s);
    longint q;
    if (s <= 0) return MAXV;
    q = (longint'(1) << (2 * FRAC)) / s;
    return (q > MAXV) ? MAXV : q;
  endfunction

  function automatic res_t model(input longint x, input longint p,
                                 input longint r, input longint z);
    res_t   m;
    longint e;
    longint inv;
    m.s = sat(p + r);
    e   = sat(z - x);
    m.e = (m.s <= 0);
    inv = m.e ? 0 : recip_val(m.s);
    m.k = mulq(p, inv);
    m.x = sat(x + mulq(m.k, e));
    m.p = sat(p - mulq(m.k, p));
    return m;
  endfunction

  function automatic longint rnd_full();
    logic signed [N-1:0] v;
    v = N'($urandom);
    return v;
  endfunction

  // External combinational reciprocal unit.
  always_comb s_recip = N'(recip_val(longint'(s_den)));

  // ---------------- stimulus helpers (no checking) ----------------
  // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 after the
  // accept edge with the operand inputs scrambled.
  task automatic send(input longint x, input longint p, input longint r, input longint z);
    x_pred   = N'(x);
    p_pred   = N'(p);
    r_meas   = N'(r);
    z_meas   = N'(z);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    x_pred   = N'($urandom);
    p_pred   = N'($urandom);
    r_meas   = N'($urandom);
    z_meas   = N'($urandom);
  endtask

  // Edges from the accept edge until out_valid; 20 means it never came.
  task automatic wait_done(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_out(input int delay);
    repeat (delay) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int lat;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    x_pred   = 20'sd5;
    p_pred   = 20'sd1024;
    r_meas   = 20'sd1024;
    z_meas   = 20'sd9;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset in_ready: got %b expected 1", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset out_valid: got %b expected 0", out_valid); else n_pass++;
    n_checks++; if (s_den !== '0) $display("FAIL reset s_den: got %0d expected 0", s_den); else n_pass++;
    n_checks++; if (k_gain !== '0) $display("FAIL reset k_gain: got %0d expected 0", k_gain); else n_pass++;
    n_checks++; if (x_upd !== '0) $display("FAIL reset x_upd: got %0d expected 0", x_upd); else n_pass++;
    n_checks++; if (p_upd !== '0) $display("FAIL reset p_upd: got %0d expected 0", p_upd); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL reset err: got %b expected 0", err); else n_pass++;
    // Release mid-cycle with in_valid still high: the first edge must accept.
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL reset first_accept in_ready: got %b expected 0", in_ready); else n_pass++;
    n_checks++; if (s_den !== 20'sd2048) $display("FAIL reset first_accept s_den: got %0d expected 2048", s_den); else n_pass++;
    wait_done(lat);
    n_checks++; if (lat != 4) $display("FAIL reset first_accept latency: got %0d expected 4", lat); else n_pass++;
    release_out(0);
  endtask

  task automatic test_directed();
    vec_t dv[4];
    int   lat;
    dv[0] = '{x: 0,       p: 1024, r: 1024, z: 2048,   exp: '{s: 2048, k: 512, x: 1024,    p: 512, e: 1'b0}};
    dv[1] = '{x: 0,       p: 1024, r: 1024, z: -3,     exp: '{s: 2048, k: 512, x: -2,      p: 512, e: 1'b0}};
    dv[2] = '{x: -524288, p: 1024, r: 1024, z: 524287, exp: '{s: 2048, k: 512, x: -262145, p: 512, e: 1'b0}};
    dv[3] = '{x: 77,      p: 0,    r: 0,    z: 100,    exp: '{s: 0,    k: 0,   x: 77,      p: 0,   e: 1'b1}};
    for (int i = 0; i < 4; i++) begin
      out_ready = 1'b1;
      send(dv[i].x, dv[i].p, dv[i].r, dv[i].z);
      n_checks++; if (longint'(s_den) != dv[i].exp.s) $display("FAIL dir[%0d] s_den: got %0d expected %0d", i, s_den, dv[i].exp.s); else n_pass++;
      wait_done(lat);
      n_checks++; if (lat != 4) $display("FAIL dir[%0d] latency: got %0d expected 4", i, lat); else n_pass++;
      n_checks++; if (longint'(k_gain) != dv[i].exp.k) $display("FAIL dir[%0d] k_gain: got %0d expected %0d", i, k_gain, dv[i].exp.k); else n_pass++;
      n_checks++; if (longint'(x_upd) != dv[i].exp.x) $display("FAIL dir[%0d] x_upd: got %0d expected %0d", i, x_upd, dv[i].exp.x); else n_pass++;
      n_checks++; if (longint'(p_upd) != dv[i].exp.p) $display("FAIL dir[%0d] p_upd: got %0d expected %0d", i, p_upd, dv[i].exp.p); else n_pass++;
      n_checks++; if (err !== dv[i].exp.e) $display("FAIL dir[%0d] err: got %b expected %b", i, err, dv[i].exp.e); else n_pass++;
      // out_ready was already high on entry to DONE: IDLE on the next cycle.
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_checks++; if (in_ready !== 1'b1) $display("FAIL dir[%0d] back_to_idle: got %b expected 1", i, in_ready); else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      longint x, p, r, z;
      int     d, lat;
      res_t   m;
      x = rnd_full();
      z = rnd_full();
      if ($urandom_range(0, 3) != 0) begin
        p = $urandom_range(0, 4095);
        r = $urandom_range(1, 4095);
      end else begin
        p = rnd_full();
        r = rnd_full();
      end
      m = model(x, p, r, z);
      d = $urandom_range(0, 3);
      out_ready = (d == 0);
      send(x, p, r, z);
      n_checks++; if (longint'(s_den) != m.s) $display("FAIL rand[%0d] s_den: got %0d expected %0d", i, s_den, m.s); else n_pass++;
      wait_done(lat);
      n_checks++; if (lat != 4) $display("FAIL rand[%0d] latency: got %0d expected 4", i, lat); else n_pass++;
      n_checks++; if (longint'(k_gain) != m.k) $display("FAIL rand[%0d] k_gain: got %0d expected %0d", i, k_gain, m.k); else n_pass++;
      n_checks++; if (longint'(x_upd) != m.x) $display("FAIL rand[%0d] x_upd: got %0d expected %0d", i, x_upd, m.x); else n_pass++;
      n_checks++; if (longint'(p_upd) != m.p) $display("FAIL rand[%0d] p_upd: got %0d expected %0d", i, p_upd, m.p); else n_pass++;
      n_checks++; if (err !== m.e) $display("FAIL rand[%0d] err: got %b expected %b", i, err, m.e); else n_pass++;
      release_out(d);
      n_checks++; if (in_ready !== 1'b1) $display("FAIL rand[%0d] back_to_idle: got %b expected 1", i, in_ready); else n_pass++;
    end
  endtask

  task automatic test_hold();
    int lat;
    bit same;
    out_ready = 1'b0;
    send(0, 1024, 1024, 2048);
    wait_done(lat);
    n_checks++; if (lat != 4) $display("FAIL hold latency: got %0d expected 4", lat); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0] ? 1'b0 : 1'b1;
      x_pred   = N'($urandom);
      p_pred   = N'($urandom);
      r_meas   = N'($urandom);
      z_meas   = N'($urandom);
      @(posedge clk); #1;
      same = (k_gain === 20'sd512) && (x_upd === 20'sd1024) && (p_upd === 20'sd512) &&
             (s_den === 20'sd2048) && (err === 1'b0);
      n_checks++; if (!same) $display("FAIL hold[%0d] outputs: got k=%0d x=%0d p=%0d s=%0d err=%b expected k=512 x=1024 p=512 s=2048 err=0", i, k_gain, x_upd, p_upd, s_den, err); else n_pass++;
      n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) $display("FAIL hold[%0d] handshake: got in_ready=%b out_valid=%b expected 0/1", i, in_ready, out_valid); else n_pass++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL hold release: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lat;
    bit seen;
    out_ready = 1'b1;
    send(0, 1024, 1024, 2048);   // now in RECIP
    @(posedge clk); #2;          // now in GAIN
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL midrst handshake: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready); else n_pass++;
    n_checks++; if (s_den !== '0) $display("FAIL midrst s_den: got %0d expected 0", s_den); else n_pass++;
    n_checks++; if (x_upd !== '0 || p_upd !== '0 || k_gain !== '0 || err !== 1'b0) $display("FAIL midrst outputs: got x=%0d p=%0d k=%0d err=%b expected all 0", x_upd, p_upd, k_gain, err); else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    n_checks++; if (seen) $display("FAIL midrst aborted_output: got out_valid=1 expected 0"); else n_pass++;
    send(0, 1024, 1024, -3);
    wait_done(lat);
    n_checks++; if (lat != 4) $display("FAIL midrst next latency: got %0d expected 4", lat); else n_pass++;
    n_checks++; if (k_gain !== 20'sd512 || x_upd !== -20'sd2 || p_upd !== 20'sd512) $display("FAIL midrst next result: got k=%0d x=%0d p=%0d expected 512/-2/512", k_gain, x_upd, p_upd); else n_pass++;
    release_out(0);
  endtask

  task automatic test_back_to_back();
    int acc[$];
    int lat;
    out_ready = 1'b1;
    x_pred    = 20'sd0;
    p_pred    = 20'sd1024;
    r_meas    = 20'sd1024;
    z_meas    = 20'sd2048;
    in_valid  = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (in_ready === 1'b1) acc.push_back(c);
      if (out_valid === 1'b1) begin
        n_checks++; if (x_upd !== 20'sd1024 || k_gain !== 20'sd512) $display("FAIL b2b result: got k=%0d x=%0d expected 512/1024", k_gain, x_upd); else n_pass++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_checks++;
    if (acc.size() < 3) $display("FAIL b2b accepts: got %0d expected at least 3", acc.size());
    else if (acc[1] - acc[0] != 6 || acc[2] - acc[1] != 6) $display("FAIL b2b spacing: got %0d,%0d expected 6,6", acc[1] - acc[0], acc[2] - acc[1]);
    else n_pass++;
    wait_done(lat);
    release_out(0);
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/kf_gain_update.md
KF_GAIN_UPDATE -- requirements
Module: kf_gain_update

Interface
REQ-001 Parameters SHALL be: N, default 20, total signed fixed-point width; FRAC, default 10, fractional bits (1.0 = 2^FRAC).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operand set valid.
REQ-005 in_ready  output  1  block idle, can accept operands.
REQ-006 x_pred, p_pred, r_meas, z_meas  input  N each, signed  predicted state, predicted covariance, measurement noise, measurement.
REQ-007 s_den  output  N, signed  innovation covariance S, driven to the external combinational reciprocal unit.
REQ-008 s_recip  input  N, signed  reciprocal of s_den, returned by that unit, combinational from s_den.
REQ-009 out_valid  output  1  results valid.
REQ-010 out_ready  input  1  downstream accepts results.
REQ-011 x_upd, p_upd, k_gain  output  N each, signed  updated state, updated covariance, Kalman gain.
REQ-012 err  output  1  S was non-positive for this update.

Function
REQ-013 The FSM SHALL have states IDLE, RECIP, GAIN, XUPD, PUPD, DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-014 IDLE: on in_valid && in_ready, register the operands, set s_den = sat(p_pred + r_meas), e = sat(z_meas - x_pred), clear err, go to RECIP; otherwise remain in IDLE.
REQ-015 RECIP: s_den is held stable for one full cycle; at the end of the cycle, register inv = s_recip, or inv = 0 with err = 1 if s_den <= 0; go to GAIN.
REQ-016 GAIN: k_gain = mul(p, inv); go to XUPD.
REQ-017 XUPD: x_upd = sat(x + mul(k_gain, e)); go to PUPD.
REQ-018 PUPD: p_upd = sat(p - mul(k_gain, p)); go to DONE.
REQ-019 DONE: on out_ready go to IDLE; otherwise hold every output unchanged.
REQ-020 Latency: out_valid SHALL rise exactly 4 clock edges after the accept edge; minimum accept-to-accept spacing is 6 cycles.
REQ-021 mul(a,b) SHALL form the full 2N-bit signed product, shift it right arithmetically by FRAC (floor, toward minus infinity), then saturate to N bits.
REQ-022 sat() SHALL clamp to [-2^(N-1), 2^(N-1)-1]; it SHALL never wrap.
REQ-023 A single shared multiplier SHALL be used, at most one product per cycle.
REQ-024 in_valid SHALL be ignored outside IDLE; input operands need not be held after the accept edge.
REQ-025 With err = 1, the results SHALL be k_gain = 0, x_upd = x_pred, p_upd = p_pred.
REQ-026 When out_ready is already high as DONE is entered, the handshake SHALL complete in that cycle and IDLE SHALL follow on the next cycle.

Reset
REQ-027 While rst_n = 0: state = IDLE; s_den, x_upd, p_upd, k_gain, err, out_valid all 0; in_ready = 1 (IDLE); in_valid not accepted.
REQ-028 Assertion of rst_n mid-operation SHALL abort immediately with no further output; the first accept is possible on the first clock edge after deassertion.

Verification (FRAC=10, recip modelled as ideal 2^20/s_den truncated, 0x7FFFF for zero)
REQ-029 p=1024, r=1024, x=0, z=2048 -> s_den=2048, k_gain=512, x_upd=1024, p_upd=512, err=0, out_valid 4 edges after accept.
REQ-030 p=1024, r=1024, x=0, z=-3 -> k_gain=512, x_upd=-2 (floor of -1.5), p_upd=512.
REQ-031 x=-524288, z=524287, p=1024, r=1024 -> e saturates to 524287, x_upd=-524288+262143=-262145, no wrap.
REQ-032 p=0, r=0, x=77 -> s_den=0, err=1, k_gain=0, x_upd=77, p_upd=0.
REQ-033 out_ready held low 5 cycles in DONE with in_valid pulsing -> outputs constant, in_ready=0, no accept; out_ready high -> IDLE the next cycle.
REQ-034 rst_n pulsed low during GAIN -> all outputs 0 asynchronously, out_valid never rises for that operand set, the next accept completes normally.
